pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
Output-side counterpart to input conditioning. Converts single-cycle event strobes from core logic into clean, human- and board-visible pulses for LEDs, buzzers and strobe pins. Every accepted event produces exactly one high pulse of HIGH_WIDTH cycles, and consecutive pulses are separated by at least LOW_WIDTH low cycles. Events that arrive while a pulse is in flight are counted and replayed, not lost, up to a saturation limit.

Parameters:
HIGH_WIDTH, 1024, output high time per event in clk cycles (>=1)
LOW_WIDTH, 1024, minimum low gap after each pulse in clk cycles (>=1)
MAX_PENDING, 15, maximum queued events (>=1)

Ports:
clk  input  1  system clock, all logic on posedge
i_reset_n  input  1  asynchronous active-low reset
i_event  input  1  event strobe; every cycle sampled high counts as one event
i_clear  input  1  synchronous flush of queued events
o_out  output  1  stretched pulse output, driven directly from a flop
o_busy  output  1  high whenever state != S_IDLE
o_pending  output  $clog2(MAX_PENDING+1)  queued event count
o_overflow  output  1  one-cycle strobe when an event is dropped at saturation

Behaviour:
- Reset (async, i_reset_n low): state S_IDLE; cnt, o_pending, o_out, o_overflow all 0. Reset asserted mid-pulse truncates o_out immediately.
- States: S_IDLE, S_HIGH, S_GAP. A single cnt of width $clog2(max(HIGH_WIDTH,LOW_WIDTH))+1 is cleared on entry to S_HIGH and S_GAP and increments by 1 each cycle in those states.
- S_IDLE: i_event=1 -> S_HIGH next cycle; o_pending unchanged.
- S_HIGH: when cnt==HIGH_WIDTH-1 -> S_GAP. Otherwise stay.
- S_GAP: when cnt==LOW_WIDTH-1:
  - o_pending>0 -> S_HIGH, o_pending decrements.
  - else i_event=1 -> S_HIGH.
  - else -> S_IDLE.
  Otherwise stay.
- Latency: o_out rises 1 cycle after the accepting i_event. It is high for exactly HIGH_WIDTH cycles, then low for at least LOW_WIDTH cycles.
- o_out is registered: o_out==1 iff state==S_HIGH, and it updates in the same edge as the state.
- Queueing: an i_event in S_HIGH, or in S_GAP not on the final gap cycle, increments o_pending.
  - On the final gap cycle with o_pending>0, an event plus the dequeue leaves o_pending unchanged.
  - If o_pending==MAX_PENDING and an increment is requested: o_pending holds and o_overflow=1 for that one cycle. The simultaneous-dequeue case is not an overflow.
- i_clear has priority over everything else in the same cycle:
  - o_pending<=0.
  - i_event that cycle is ignored.
  - An in-flight pulse and gap complete normally, so minimum widths are never violated.
- o_overflow is 0 on every cycle not described above.
- o_busy is combinational from state.

Decomposition:
- Package pulse_stretcher_pkg holds the state enum typedef (S_IDLE, S_HIGH, S_GAP) and a function computing the counter width from HIGH_WIDTH and LOW_WIDTH.
- One sub-module: sat_updown_counter (parameter MAX; inputs inc, dec, clr; outputs count, overflow strobe). It is reusable for other queued-event blocks.
- FSM and timer stay in the top module.

Test Plan:
- HIGH_WIDTH=4, LOW_WIDTH=3; single i_event at cycle 0 -> o_out high cycles 1-4, low 5-7; o_busy low from cycle 8; o_pending stays 0.
- Same params; events at cycles 0 and 5 -> pulses at cycles 1-4 and 8-11; o_pending=1 during cycles 6-7, 0 from cycle 8.
- Same params; event on final gap cycle 7 with o_pending=0 -> next pulse at cycles 8-11, o_pending never nonzero. Repeat with o_pending=1 -> o_pending stays 1.
- MAX_PENDING=2; i_event held high for 6 cycles from cycle 0 -> o_pending saturates at 2; o_overflow strobes on cycles 3, 4 and 5; exactly 3 pulses emitted in total.
- Queue 2 events, assert i_clear together with i_event mid-pulse -> o_pending=0 next cycle; the current pulse completes its full 4 cycles; no further pulses.
- Assert i_reset_n low asynchronously (between edges) during S_HIGH -> o_out=0 without waiting for a clock edge; all outputs 0; after release, a new i_event gives a normal full-width pulse.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg: FSM state encoding and timer width helper for pulse_stretcher.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_GAP} state_t;

    function automatic int cnt_width(input int high_width, input int low_width);
        return $clog2(high_width > low_width ? high_width : low_width) + 1;
    endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// sat_updown_counter: saturating queue counter with flush and a drop strobe at saturation.
module sat_updown_counter #(
    parameter int MAX = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       inc,
    input  logic                       dec,
    input  logic                       clr,
    output logic [$clog2(MAX+1)-1:0]   count,
    output logic                       overflow
);
    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] TOP = W'(MAX);

    logic full;
    assign full = count == TOP;
    // a simultaneous dequeue makes room, so only a lone increment at the top is dropped
    assign overflow = inc & ~dec & ~clr & full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc & ~dec & ~full)
            count <= count + 1'b1;
        else if (dec & ~inc & (count != '0))
            count <= count - 1'b1;
    end

endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches event strobes into HIGH_WIDTH pulses with LOW_WIDTH gaps,
// replaying events that arrive while a pulse or gap is in flight.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HIGH_WIDTH  = 1024,
    parameter int LOW_WIDTH   = 1024,
    parameter int MAX_PENDING = 15
) (
    input  logic                               clk,
    input  logic                               i_reset_n,
    input  logic                               i_event,
    input  logic                               i_clear,
    output logic                               o_out,
    output logic                               o_busy,
    output logic [$clog2(MAX_PENDING+1)-1:0]   o_pending,
    output logic                               o_overflow
);
    localparam int CW = cnt_width(HIGH_WIDTH, LOW_WIDTH);
    localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_WIDTH - 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_WIDTH - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            ev, has_pending, high_done, gap_done, inc, dec;

    // a flush suppresses both the new event and any replay in the same cycle
    assign ev          = i_event & ~i_clear;
    assign has_pending = (o_pending != '0) & ~i_clear;
    assign high_done   = (state == S_HIGH) && (cnt == HIGH_LAST);
    assign gap_done    = (state == S_GAP) && (cnt == LOW_LAST);
    assign inc         = ev & ((state == S_HIGH) | ((state == S_GAP) & (~gap_done | has_pending)));
    assign dec         = gap_done & has_pending;
    assign o_busy      = state != S_IDLE;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = ev ? S_HIGH : S_IDLE;
            S_HIGH:  state_nxt = high_done ? S_GAP : S_HIGH;
            S_GAP:   state_nxt = gap_done ? ((has_pending | ev) ? S_HIGH : S_IDLE) : S_GAP;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            o_out <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state || state_nxt == S_IDLE) ? '0 : cnt + 1'b1;
            o_out <= state_nxt == S_HIGH;
        end
    end

    sat_updown_counter #(.MAX(MAX_PENDING)) u_pending (
        .clk      (clk),
        .rst_n    (i_reset_n),
        .inc      (inc),
        .dec      (dec),
        .clr      (i_clear),
        .count    (o_pending),
        .overflow (o_overflow)
    );

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: vector table, async reset sequence and random traffic against a timeline model.
module tb_pulse_stretcher;
    localparam int H = 4;
    localparam int L = 3;
    localparam int M = 2;

    logic       clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_event = 1'b0;
    logic       i_clear = 1'b0;
    logic       o_out, o_busy, o_overflow;
    logic [1:0] o_pending;

    int n_chk = 0;
    int n_fail = 0;

    // model: the current pulse occupies [s, s+H) high then [s+H, s+H+L) low
    longint t = 0;
    longint s = -1000;
    int     p = 0;
    logic   m_out, m_busy, m_ovf;
    int     m_pend;

    typedef struct {
        int   n;
        logic ev, clr, out, busy;
        int   pend;
        logic ovf;
    } vec_t;
    vec_t tbl[$];

    pulse_stretcher #(.HIGH_WIDTH(H), .LOW_WIDTH(L), .MAX_PENDING(M)) dut (
        .clk        (clk),
        .i_reset_n  (i_reset_n),
        .i_event    (i_event),
        .i_clear    (i_clear),
        .o_out      (o_out),
        .o_busy     (o_busy),
        .o_pending  (o_pending),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic ev, input logic clr, input logic out,
                       input logic busy, input int pend, input logic ovf);
        vec_t v;
        v.n = n; v.ev = ev; v.clr = clr; v.out = out; v.busy = busy; v.pend = pend; v.ovf = ovf;
        tbl.push_back(v);
    endtask

    task automatic model_reset();
        s = -1000;
        p = 0;
    endtask

    task automatic cyc(input logic ev, input logic clr);
        logic act, fin, dq, qr;
        @(negedge clk);
        i_event = ev;
        i_clear = clr;
        #1;
        act    = (t >= s) && (t < s + H + L);
        fin    = act && (t == s + H + L - 1);
        m_out  = (t >= s) && (t < s + H);
        m_busy = act;
        m_pend = p;
        dq     = !clr && fin && (p > 0);
        qr     = !clr && ev && act && !(fin && p == 0);
        m_ovf  = qr && !dq && (p == M);
        check($sformatf("model out t=%0d", t), {31'd0, o_out}, {31'd0, m_out});
        check($sformatf("model busy t=%0d", t), {31'd0, o_busy}, {31'd0, m_busy});
        check($sformatf("model pending t=%0d", t), {30'd0, o_pending}, m_pend);
        check($sformatf("model overflow t=%0d", t), {31'd0, o_overflow}, {31'd0, m_ovf});
        if (clr)
            p = 0;
        else if (!act) begin
            if (ev) s = t + 1;
        end else if (fin) begin
            if (p > 0) begin
                s = t + 1;
                if (!ev) p--;
            end else if (ev)
                s = t + 1;
        end else if (ev && p < M)
            p++;
        t++;
    endtask

    initial begin
        int hi;
        logic done;
        // single event
        add(1,1,0,0,0,0,0); add(4,0,0,1,1,0,0); add(3,0,0,0,1,0,0); add(1,0,0,0,0,0,0);
        // events at cycles 0 and 5
        add(1,1,0,0,0,0,0); add(4,0,0,1,1,0,0); add(1,1,0,0,1,0,0); add(2,0,0,0,1,1,0);
        add(4,0,0,1,1,0,0); add(3,0,0,0,1,0,0); add(1,0,0,0,0,0,0);
        // event on final gap cycle with nothing queued
        add(1,1,0,0,0,0,0); add(4,0,0,1,1,0,0); add(2,0,0,0,1,0,0); add(1,1,0,0,1,0,0);
        add(4,0,0,1,1,0,0); add(3,0,0,0,1,0,0); add(1,0,0,0,0,0,0);
        // event on final gap cycle with one queued
        add(1,1,0,0,0,0,0); add(4,0,0,1,1,0,0); add(1,1,0,0,1,0,0); add(1,0,0,0,1,1,0);
        add(1,1,0,0,1,1,0); add(4,0,0,1,1,1,0); add(3,0,0,0,1,1,0); add(4,0,0,1,1,0,0);
        add(3,0,0,0,1,0,0); add(1,0,0,0,0,0,0);
        // saturation with event held six cycles
        add(1,1,0,0,0,0,0); add(1,1,0,1,1,0,0); add(1,1,0,1,1,1,0); add(2,1,0,1,1,2,1);
        add(1,1,0,0,1,2,1); add(2,0,0,0,1,2,0); add(4,0,0,1,1,1,0); add(3,0,0,0,1,1,0);
        add(4,0,0,1,1,0,0); add(3,0,0,0,1,0,0); add(1,0,0,0,0,0,0);
        // clear together with an event mid-pulse
        add(1,1,0,0,0,0,0); add(1,1,0,1,1,0,0); add(1,1,0,1,1,1,0); add(1,1,1,1,1,2,0);
        add(1,0,0,1,1,0,0); add(3,0,0,0,1,0,0); add(2,0,0,0,0,0,0);

        repeat (2) @(negedge clk);
        check("reset out", {31'd0, o_out}, 0);
        check("reset busy", {31'd0, o_busy}, 0);
        check("reset pending", {30'd0, o_pending}, 0);
        check("reset overflow", {31'd0, o_overflow}, 0);
        i_reset_n = 1'b1;
        model_reset();

        foreach (tbl[k])
            for (int r = 0; r < tbl[k].n; r++) begin
                cyc(tbl[k].ev, tbl[k].clr);
                check($sformatf("tbl%0d.%0d out", k, r), {31'd0, o_out}, {31'd0, tbl[k].out});
                check($sformatf("tbl%0d.%0d busy", k, r), {31'd0, o_busy}, {31'd0, tbl[k].busy});
                check($sformatf("tbl%0d.%0d pending", k, r), {30'd0, o_pending}, tbl[k].pend);
                check($sformatf("tbl%0d.%0d overflow", k, r), {31'd0, o_overflow}, {31'd0, tbl[k].ovf});
            end

        // asynchronous reset in the middle of a pulse with one event queued
        cyc(1, 0);
        cyc(1, 0);
        cyc(0, 0);
        check("pre-reset out", {31'd0, o_out}, 1);
        check("pre-reset pending", {30'd0, o_pending}, 1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("async reset out", {31'd0, o_out}, 0);
        check("async reset busy", {31'd0, o_busy}, 0);
        check("async reset pending", {30'd0, o_pending}, 0);
        check("async reset overflow", {31'd0, o_overflow}, 0);
        model_reset();
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;
        cyc(1, 0);
        hi = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            cyc(0, 0);
            if (o_out) hi++;
            if (!o_busy) done = 1'b1;
        end
        check("post-reset pulse ends", {31'd0, done}, 1);
        check("post-reset pulse width", hi, H);

        for (int i = 0; i < 600; i++) begin
            int dens;
            dens = ((i / 80) % 3 == 0) ? 70 : ((i / 80) % 3 == 1) ? 25 : 5;
            cyc($urandom_range(0, 99) < dens, $urandom_range(0, 99) < 4);
        end
        repeat (25) cyc(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
